// File: rtl/sched_pkg.sv
// Shared encodings for the quantum scheduler: FSM states and flagSetValue codes.
package sched_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StSwitch = 2'd2
    } sched_state_e;

    localparam logic [1:0] SET_NONE       = 2'd0;
    localparam logic [1:0] SET_QUANTUM_V  = 2'd1;
    localparam logic [1:0] SET_MULTIPROG_V = 2'd2;
    localparam logic [1:0] SET_ADDR_CS_V  = 2'd3;

    localparam int unsigned CS_COUNT_WIDTH = 16;

endpackage

// File: rtl/quantum_counter.sv
// Loadable down-counter for the preemption quantum; load beats decrement beats hold.
module quantum_counter #(
    parameter int unsigned QUANTUM_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [QUANTUM_WIDTH-1:0] load_value,
    input  logic                     decrement,
    output logic [QUANTUM_WIDTH-1:0] count,
    output logic                     expired
);

    logic [QUANTUM_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decrement && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A retire at zero is treated as expiry too, so the FSM can never get stuck in RUN.
    assign expired = decrement && (count_q <= QUANTUM_WIDTH'(1));
    assign count   = count_q;

endmodule

// File: rtl/quantum_scheduler.sv
// Preemption timer and context-switch sequencer. Optional CS_COUNTER_EN adds a
// 16-bit count of entries into SWITCH on output csCount.
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned QUANTUM_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  interruption,
    input  logic [1:0]            flagSetValue,
    input  logic [DATA_WIDTH-1:0] setData,
    input  logic                  flagExecProc,
    input  logic                  flagHALT,
    input  logic                  instrRetire,
    input  logic [ADDR_WIDTH-1:0] pcNext,
    output logic                  flagCS,
    output logic [ADDR_WIDTH-1:0] addrCS,
    output logic [ADDR_WIDTH-1:0] pcSaved,
    output logic                  procDone,
    output logic                  multiprogEn,
    output logic                  running
`ifdef CS_COUNTER_EN
   ,output logic [CS_COUNT_WIDTH-1:0] csCount
`endif
);

    sched_state_e state_q, state_d;

    logic [QUANTUM_WIDTH-1:0] quantum_q;
    logic                     multiprog_q;
    logic [ADDR_WIDTH-1:0]    addr_cs_q;
    logic [ADDR_WIDTH-1:0]    pc_saved_q;
    logic                     proc_done_q;

    logic                     cnt_load;
    logic                     cnt_dec;
    logic                     cnt_expired;
    logic [QUANTUM_WIDTH-1:0] unused_count;
    logic                     capture_pc;
    logic                     halt_taken;
    logic                     unused_set_bits;

    assign unused_set_bits = ^setData;

    // Kept outside the FSM block so the expiry flag does not loop back into it.
    assign cnt_dec = !interruption && (state_q == StRun) && instrRetire && !flagHALT;

    quantum_counter #(
        .QUANTUM_WIDTH(QUANTUM_WIDTH)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(quantum_q),
        .decrement (cnt_dec),
        .count     (unused_count),
        .expired   (cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        capture_pc = 1'b0;
        halt_taken = 1'b0;
        if (!interruption) begin
            unique case (state_q)
                StIdle: begin
                    if (flagExecProc && multiprog_q && (quantum_q != '0)) begin
                        state_d  = StRun;
                        cnt_load = 1'b1;
                    end
                end
                StRun: begin
                    if (flagHALT) begin
                        state_d    = StSwitch;
                        capture_pc = 1'b1;
                        halt_taken = 1'b1;
                    end else if (cnt_expired) begin
                        state_d    = StSwitch;
                        capture_pc = 1'b1;
                    end
                end
                StSwitch: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_saved_q  <= '0;
            proc_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proc_done_q <= halt_taken;
            if (capture_pc) begin
                pc_saved_q <= pcNext;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quantum_q   <= '0;
            multiprog_q <= 1'b0;
            addr_cs_q   <= '0;
        end else if (!interruption) begin
            case (flagSetValue)
                SET_QUANTUM_V:   quantum_q   <= setData[QUANTUM_WIDTH-1:0];
                SET_MULTIPROG_V: multiprog_q <= setData[0];
                SET_ADDR_CS_V:   addr_cs_q   <= setData[ADDR_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef CS_COUNTER_EN
    logic [CS_COUNT_WIDTH-1:0] cs_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_count_q <= '0;
        end else if ((state_d == StSwitch) && (state_q != StSwitch)) begin
            cs_count_q <= cs_count_q + 1'b1;
        end
    end

    assign csCount = cs_count_q;
`endif

    assign flagCS      = (state_q == StSwitch);
    assign running     = (state_q == StRun);
    assign addrCS      = addr_cs_q;
    assign pcSaved     = pc_saved_q;
    assign procDone    = proc_done_q;
    assign multiprogEn = multiprog_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Randomized plus directed bench for quantum_scheduler against a behavioural model.
module tb_quantum_scheduler;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned QW = 16;

    logic          clock;
    logic          reset;
    logic          interruption;
    logic [1:0]    flagSetValue;
    logic [DW-1:0] setData;
    logic          flagExecProc;
    logic          flagHALT;
    logic          instrRetire;
    logic [AW-1:0] pcNext;
    logic          flagCS;
    logic [AW-1:0] addrCS;
    logic [AW-1:0] pcSaved;
    logic          procDone;
    logic          multiprogEn;
    logic          running;
`ifdef CS_COUNTER_EN
    logic [15:0]   csCount;
`endif

    quantum_scheduler #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .QUANTUM_WIDTH(QW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .interruption(interruption),
        .flagSetValue(flagSetValue),
        .setData     (setData),
        .flagExecProc(flagExecProc),
        .flagHALT    (flagHALT),
        .instrRetire (instrRetire),
        .pcNext      (pcNext),
        .flagCS      (flagCS),
        .addrCS      (addrCS),
        .pcSaved     (pcSaved),
        .procDone    (procDone),
        .multiprogEn (multiprogEn),
        .running     (running)
`ifdef CS_COUNTER_EN
       ,.csCount     (csCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a process is "running" with some retires left; a switch lasts one unfrozen cycle.
    int unsigned m_quantum;
    bit          m_mp;
    int unsigned m_addr;
    int unsigned m_pc_saved;
    bit          m_run;
    bit          m_switch;
    bit          m_done;
    int          m_left;
    int unsigned m_cs_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_quantum  = 0;
        m_mp       = 0;
        m_addr     = 0;
        m_pc_saved = 0;
        m_run      = 0;
        m_switch   = 0;
        m_done     = 0;
        m_left     = 0;
        m_cs_count = 0;
    endtask

    task automatic model_step();
        bit enter_switch;
        bit done_next;
        enter_switch = 0;
        done_next    = 0;
        if (interruption) begin
            m_done = 0;
        end else begin
            if (m_switch) begin
                m_switch = 0;
            end else if (m_run) begin
                if (flagHALT) begin
                    enter_switch = 1;
                    done_next    = 1;
                end else if (instrRetire) begin
                    m_left = m_left - 1;
                    if (m_left <= 0) enter_switch = 1;
                end
            end else if (flagExecProc && m_mp && m_quantum != 0) begin
                m_run  = 1;
                m_left = int'(m_quantum);
            end
            if (enter_switch) begin
                m_run      = 0;
                m_switch   = 1;
                m_pc_saved = pcNext;
                m_cs_count = (m_cs_count + 1) % 65536;
            end
            m_done = done_next;
            case (flagSetValue)
                2'd1: m_quantum = setData % 65536;
                2'd2: m_mp      = setData[0];
                2'd3: m_addr    = setData % 1024;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check_eq("flagCS", flagCS, m_switch);
        check_eq("running", running, m_run);
        check_eq("procDone", procDone, m_done);
        check_eq("multiprogEn", multiprogEn, m_mp);
        check_eq("addrCS", addrCS, m_addr);
        check_eq("pcSaved", pcSaved, m_pc_saved);
`ifdef CS_COUNTER_EN
        check_eq("csCount", csCount, m_cs_count);
`endif
    endtask

    // Apply one cycle of inputs, step the model at the edge, compare just after it.
    task automatic op(input bit exec, input bit halt, input bit retire, input bit intr,
                      input logic [1:0] fsv, input logic [31:0] data, input logic [AW-1:0] pc);
        flagExecProc = exec;
        flagHALT     = halt;
        instrRetire  = retire;
        interruption = intr;
        flagSetValue = fsv;
        setData      = data;
        pcNext       = pc;
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, 0, 0, 2'd0, 32'h0, 10'h0);
    endtask

    task automatic retire(input logic [AW-1:0] pc);
        op(0, 0, 1, 0, 2'd0, 32'h0, pc);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        interruption = 0; flagSetValue = 0; setData = 0;
        flagExecProc = 0; flagHALT = 0; instrRetire = 0; pcNext = 0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Quantum expiry after three retires
        op(0, 0, 0, 0, 2'd1, 32'hABCD_0003, 10'h0);
        op(0, 0, 0, 0, 2'd2, 32'h0000_0001, 10'h0);
        op(0, 0, 0, 0, 2'd3, 32'hFFFF_F040, 10'h0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        retire(10'h101);
        retire(10'h102);
        retire(10'h105);
        check_eq("t2_cs_high", flagCS, 1);
        check_eq("t2_addr", addrCS, 32'h040);
        check_eq("t2_pc", pcSaved, 32'h105);
        idle(1);
        check_eq("t2_cs_low", flagCS, 0);
        check_eq("t2_idle", running, 0);

        // HLT at counter 2, then HLT together with the final retire
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        retire(10'h011);
        op(0, 1, 0, 0, 2'd0, 32'h0, 10'h0A0);
        check_eq("t3_cs", flagCS, 1);
        check_eq("t3_done", procDone, 1);
        check_eq("t3_pc", pcSaved, 32'h0A0);
        idle(1);
        check_eq("t3_done_low", procDone, 0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        retire(10'h021);
        retire(10'h022);
        op(0, 1, 1, 0, 2'd0, 32'h0, 10'h0B0);
        check_eq("t3b_cs", flagCS, 1);
        check_eq("t3b_pc", pcSaved, 32'h0B0);
        idle(3);

        // No preemption with multiprogramming off, or with a zero quantum
        op(0, 0, 0, 0, 2'd2, 32'h0, 10'h0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        for (int i = 0; i < 100; i++) retire(10'(i));
        check_eq("t4_run", running, 0);
        op(0, 0, 0, 0, 2'd2, 32'h1, 10'h0);
        op(0, 0, 0, 0, 2'd1, 32'h0001_0000, 10'h0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        for (int i = 0; i < 20; i++) retire(10'(i));
        check_eq("t4_q0_run", running, 0);

        // Interruption freezes counter and config writes
        op(0, 0, 0, 0, 2'd1, 32'h3, 10'h0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        retire(10'h031);
        for (int i = 0; i < 4; i++) op(0, 0, 1, 1, 2'd1, 32'h9, 10'h3FF);
        retire(10'h032);
        check_eq("t5_still_run", running, 1);
        retire(10'h033);
        check_eq("t5_cs", flagCS, 1);
        op(0, 0, 0, 1, 2'd0, 32'h0, 10'h0);
        op(0, 0, 0, 1, 2'd0, 32'h0, 10'h0);
        check_eq("t5_cs_held", flagCS, 1);
        idle(1);
        check_eq("t5_cs_clear", flagCS, 0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        retire(10'h041);
        retire(10'h042);
        retire(10'h043);
        check_eq("t5_q_kept", flagCS, 1);
        idle(1);

        // Asynchronous reset in the middle of a run with the counter at 5
        op(0, 0, 0, 0, 2'd1, 32'h5, 10'h0);
        op(1, 0, 0, 0, 2'd0, 32'h0, 10'h0);
        check_eq("t1_pre_run", running, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3;
        reset = 1'b1;
        idle(2);

        // Random traffic
        op(0, 0, 0, 0, 2'd2, 32'h1, 10'h0);
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  fsv;
            logic [31:0] data;
            fsv  = ($urandom_range(0, 99) < 8) ? 2'($urandom_range(1, 3)) : 2'd0;
            data = $urandom;
            if (fsv == 2'd1) data = (data & 32'hFFFF_0000) | $urandom_range(0, 6);
            if (fsv == 2'd2) data[0] = ($urandom_range(0, 9) < 8);
            op($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
               $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10,
               fsv, data, 10'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quantum_scheduler.md
Name: quantum_scheduler

Overview:
Preemption timer and context-switch sequencer for multiprogramming mode. Holds the quantum, multiprogramming enable and context-switch handler address written by the SET_QUANTUM / SET_MULTIPROG / SET_ADDR_CS instructions. Counts retired user-process instructions after EXEC_PROCESS and raises flagCS, which the control unit consumes to force a jump to the OS handler. Captures the preempted process PC so GET_PC_PROCESS can read it.

Parameters:
ADDR_WIDTH, 10, instruction-memory address width
DATA_WIDTH, 32, register-file data width (source of set values)
QUANTUM_WIDTH, 16, quantum counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
interruption  in  1  processor stalled (waiting on IN); freezes block
flagSetValue  in  2  from control unit: 1=quantum, 2=multiprog, 3=CS address, 0=none
setData  in  DATA_WIDTH  register value written by the SET_* instructions
flagExecProc  in  1  EXEC_PROCESS decoded this cycle
flagHALT  in  1  HLT decoded this cycle
instrRetire  in  1  one-cycle pulse per completed instruction
pcNext  in  ADDR_WIDTH  PC the processor would execute next
flagCS  out  1  context-switch request to control unit
addrCS  out  ADDR_WIDTH  handler address; PC source while flagCS=1
pcSaved  out  ADDR_WIDTH  PC of the last preempted or halted process
procDone  out  1  one-cycle pulse: the running process executed HLT
multiprogEn  out  1  multiprogramming enabled
running  out  1  user process under quantum control

Behaviour:
- Reset (reset=0, async): state IDLE; quantumReg, addrCS, pcSaved and counter cleared to 0; multiprogEn, flagCS, procDone and running cleared to 0.
- Config writes happen on a clock edge when interruption=0. flagSetValue=1 sets quantumReg=setData[QUANTUM_WIDTH-1:0]. flagSetValue=2 sets multiprogEn=setData[0]. flagSetValue=3 sets addrCS=setData[ADDR_WIDTH-1:0]. Writes are accepted in any state. A quantum write during RUN affects only the next load.
- States: IDLE, RUN, SWITCH.
- IDLE -> RUN on flagExecProc=1, multiprogEn=1 and quantumReg!=0. The counter loads quantumReg.
- flagExecProc with multiprogEn=0 or quantum=0 stays in IDLE. The process then runs unpreempted.
- RUN: each instrRetire decrements the counter. A retire while counter==1 moves to SWITCH and captures pcSaved=pcNext.
- RUN: flagHALT=1 moves to SWITCH, captures pcSaved=pcNext, and pulses procDone in the same edge's following cycle. flagHALT takes priority over the quantum-expiry retire in the same cycle.
- SWITCH: flagCS=1 for exactly one cycle, decoded from the state register. The control unit uses addrCS as the next PC. Next state is IDLE; running=0.
- running=1 only in RUN. flagCS=1 only in SWITCH.
- interruption=1: no state transition, counter hold, no config write. If interruption rises while in SWITCH, flagCS stays high until it clears.
- Clearing multiprogEn during RUN completes the current quantum; no new RUN is entered.
- Counter never underflows. A retire at counter 0 is impossible by construction; if it occurs, transition to SWITCH.

Optional Feature:
CS_COUNTER_EN:
- Defined: adds output csCount (16 bits), reset to 0. It increments once per entry to SWITCH, wraps from 0xFFFF to 0, and is frozen by interruption like the state.
- Undefined: the port and the register are absent; all other behaviour is identical.

Decomposition:
- Shared package sched_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, SWITCH=2'd2) and the flagSetValue codes (SET_NONE=0, SET_QUANTUM_V=1, SET_MULTIPROG_V=2, SET_ADDR_CS_V=3).
- One sub-module, quantum_counter: loadable down-counter with a load/decrement/hold priority and an expiry flag (counter==1 and decrement). The FSM, config registers and PC capture stay in quantum_scheduler.

Test Plan:
1. Reset asserted mid-RUN with counter=5 -> all outputs 0 immediately, without waiting for a clock; state IDLE after release.
2. Quantum expiry: SET_QUANTUM 3, SET_MULTIPROG 1, SET_ADDR_CS 0x040, EXEC_PROCESS, then 3 retires with pcNext=0x105 on the third -> flagCS high for exactly one cycle after the third retire, addrCS=0x040, pcSaved=0x105, then IDLE.
3. HLT in RUN at counter 2 with pcNext=0x0A0 -> flagCS and procDone one cycle each, pcSaved=0x0A0. The same-cycle retire at counter 1 plus HLT produces a single switch.
4. EXEC_PROCESS with multiprogEn=0 (or quantum=0) -> running stays 0; 100 retires produce no flagCS.
5. interruption=1 held 4 cycles in RUN at counter 2 with retire pulses and SET_QUANTUM 9 -> counter stays 2 and quantumReg is unchanged; the second retire after release yields flagCS.
6. CS_COUNTER_EN defined: two preemptions -> csCount=2. Preset to 0xFFFF via repeated switches in a fast test -> next switch wraps it to 0.
